demux_dispatch_14: RTL and testbench
====================================

DEMUX_DISPATCH_14 -- requirements
Module: demux_dispatch_14

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 din  input  WIDTH  upstream data word.
REQ-005 din_valid  input  1  upstream word present.
REQ-006 din_ready  output  1  block accepts din this cycle.
REQ-007 sel  input  2  destination lane, 0..3; sampled with din (ignored when DEMUX_RR_EN is defined).
REQ-008 dout  output  4*WIDTH  lane k data on bits [k*WIDTH +: WIDTH].
REQ-009 dout_valid  output  4  per-lane word present.
REQ-010 dout_ready  input  4  per-lane downstream accept.
REQ-011 xfer_cnt  output  16  count of accepted input words, wrapping.

Function
REQ-012 Transfer in occurs when din_valid && din_ready at a rising edge; transfer out on lane k when dout_valid[k] && dout_ready[k].
REQ-013 Each lane SHALL hold one word in a holding register; target lane t = sel (or RR pointer).
REQ-014 din_ready SHALL be combinational: !dout_valid[t] || dout_ready[t]; SHALL be 0 while rst is high.
REQ-015 Latency: word accepted at edge N appears on lane t with dout_valid[t]=1 after edge N; no combinational din-to-dout path.
REQ-016 Same-cycle drain and fill of lane t: new word loaded, dout_valid[t] stays 1, no bubble.
REQ-017 Drain without fill: dout_valid[k] clears at that edge; lane data slice returns to 0.
REQ-018 While dout_valid[k]=1 and dout_ready[k]=0, lane k data SHALL remain stable.
REQ-019 Slices of lanes with dout_valid[k]=0 SHALL read all zeros.
REQ-020 Non-target lanes drain independently in the same cycle as a fill of t.
REQ-021 xfer_cnt increments by 1 per accepted word; 16'hFFFF wraps to 0.
REQ-022 A full non-target lane never blocks din; only lane t's state gates din_ready.
REQ-023 sel changes while din_valid=0 have no effect.

Reset
REQ-024 On rst at a rising edge: dout_valid=4'b0000, dout=0, xfer_cnt=0, RR pointer=0.
REQ-025 Reset mid-operation discards held words; no transfer in or out is counted in that cycle.
REQ-026 First accept possible on the first edge after rst deasserts.

Configuration
REQ-027 Macro DEMUX_RR_EN: when defined, sel is ignored; t = internal 2-bit pointer, advancing by 1 after each accepted word, wrapping 3->0; pointer holds when no accept.
REQ-028 Without DEMUX_RR_EN: t = sel; no pointer register exists.

Structure
REQ-029 Shared package demux_pkg: LANES=4, SEL_W=2, typedef lane_idx_t (2-bit).
REQ-030 Sub-module demux_lane_reg: one-entry holding register with load, drain, valid, data-zeroing; instantiated 4 times.
REQ-031 Top contains lane decode, din_ready mux, RR pointer (conditional), xfer_cnt.

Verification
REQ-032 rst high 2 cycles, then sel=2, din=8'hA5, din_valid=1 one cycle, dout_ready=0 -> next cycle dout_valid=4'b0100, lane2=8'hA5, others 0, xfer_cnt=1.
REQ-033 Lane 2 full, dout_ready=0, sel=2, din_valid=1 -> din_ready=0, nothing accepted; then sel=1 -> din_ready=1, lane1 loads.
REQ-034 Lane 0 full, dout_ready[0]=1, sel=0, din=8'h3C -> din_ready=1; next cycle lane0=8'h3C, dout_valid[0] stays 1.
REQ-035 Preload xfer_cnt to 16'hFFFF via 65535 accepts, one more accept -> xfer_cnt=0.
REQ-036 DEMUX_RR_EN defined, 5 back-to-back words 1..5, all dout_ready=1 -> lanes 0,1,2,3,0 receive 1,2,3,4,5; sel toggling has no effect.
REQ-037 Lanes 1 and 3 full, assert rst one cycle -> dout_valid=0, dout=0, xfer_cnt=0, din_ready=0 during rst.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the four-lane demultiplexing dispatcher.
package demux_pkg;

    localparam int LANES = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 16;

    typedef logic [SEL_W-1:0] lane_idx_t;

    // One-hot lane mask for a lane index, used to steer the load strobe.
    function automatic logic [LANES-1:0] lane_onehot(input lane_idx_t idx);
        logic [LANES-1:0] one;
        one = {{(LANES-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One-entry holding register for a single output lane. The data output is
// zero whenever the entry is empty, so the top can wire it straight to dout.
module demux_lane_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Drain empties and zeroes the entry; a load in the same cycle overrides it.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && drain) begin
            valid_d = 1'b0;
            data_d  = '0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end
    end

    // Entry state register; reset discards any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/demux_dispatch_14.sv
// Four-lane dispatcher: each accepted input word is written into the holding
// register of one target lane. The target is taken from sel, or, when the
// macro DEMUX_RR_EN is defined, from an internal round-robin pointer that
// advances after every accepted word. Also counts accepted words (wrapping).
module demux_dispatch_14
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       din,
    input  logic                   din_valid,
    output logic                   din_ready,
    input  logic [SEL_W-1:0]       sel,
    output logic [LANES*WIDTH-1:0] dout,
    output logic [LANES-1:0]       dout_valid,
    input  logic [LANES-1:0]       dout_ready,
    output logic [CNT_W-1:0]       xfer_cnt
);

    lane_idx_t        target;
    logic             accept;
    logic [LANES-1:0] load_vec;
    logic [LANES-1:0] lane_valid;
    logic [CNT_W-1:0] xfer_cnt_q;
    logic [CNT_W-1:0] xfer_cnt_d;

`ifdef DEMUX_RR_EN
    lane_idx_t rr_ptr_q;
    lane_idx_t rr_ptr_d;
    logic      sel_unused;

    assign sel_unused = ^sel;

    // Pointer picks the target lane and steps to the next lane on each accept.
    always_comb begin
        target   = rr_ptr_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = rr_ptr_q + lane_idx_t'(1);
        end
    end

    // Round-robin pointer register, restarting at lane 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Target lane comes directly from the upstream select.
    always_comb begin
        target = sel;
    end
`endif

    // Only the target lane's occupancy gates the input; nothing enters during reset.
    always_comb begin
        din_ready = 1'b0;
        if (!rst) begin
            din_ready = !lane_valid[target] || dout_ready[target];
        end
        accept   = din_valid && din_ready;
        load_vec = '0;
        if (accept) begin
            load_vec = lane_onehot(target);
        end
    end

    // Accepted-word counter, wrapping naturally at the top of its range.
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (accept) begin
            xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        demux_lane_reg #(
            .WIDTH(WIDTH)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .load     (load_vec[k]),
            .drain    (dout_ready[k]),
            .load_data(din),
            .valid    (lane_valid[k]),
            .data     (dout[k*WIDTH +: WIDTH])
        );
    end

    assign dout_valid = lane_valid;
    assign xfer_cnt   = xfer_cnt_q;

endmodule

// File: tb/tb_demux_dispatch_14.sv
// Self-checking bench for demux_dispatch_14. Expected lane words are queued
// per lane when stimulus is issued; a monitor compares them as lanes present
// data. Covers the sel-driven build by default, round-robin with DEMUX_RR_EN.
module tb_demux_dispatch_14;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  din = 8'h00;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [1:0]  sel = 2'd0;
    logic [31:0] dout;
    logic [3:0]  dout_valid;
    logic [3:0]  dout_ready = 4'b0000;
    logic [15:0] xfer_cnt;

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic [7:0]  lane_q [4][$];

    demux_dispatch_14 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .sel       (sel),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .xfer_cnt  (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one valid word; the caller sits just after a rising edge.
    task automatic applyStimulus(input logic [1:0] s, input logic [7:0] d, input logic [3:0] rdy,
                                 input logic exp_rdy, input int exp_lane);
        sel        = s;
        din        = d;
        din_valid  = 1'b1;
        dout_ready = rdy;
        @(negedge clk);
        checkOutput("din_ready", {31'b0, din_ready}, {31'b0, exp_rdy});
        if (exp_rdy) lane_q[exp_lane].push_back(d);
        @(posedge clk);
        #1;
        if (exp_rdy) exp_cnt++;
        din_valid = 1'b0;
    endtask

    task automatic idleCycle(input logic [1:0] s, input logic [3:0] rdy);
        sel        = s;
        din_valid  = 1'b0;
        dout_ready = rdy;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int n);
        rst       = 1'b1;
        din_valid = 1'b0;
        din       = 8'hFF;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("din_ready_in_rst", {31'b0, din_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        rst     = 1'b0;
        exp_cnt = 16'd0;
    endtask

    task automatic checkState(input string tag, input logic [3:0] v, input logic [31:0] d);
        checkOutput({tag, "_valid"}, {28'b0, dout_valid}, {28'b0, v});
        checkOutput({tag, "_dout"}, dout, d);
        checkOutput({tag, "_cnt"}, {16'b0, xfer_cnt}, {16'b0, exp_cnt});
    endtask

    // Monitor: compare each presented lane word with the head of its queue.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) lane_q[k].delete();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (dout_valid[k]) begin
                    if (lane_q[k].size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL lane%0d_unexpected_valid: actual=1 required=0", k);
                    end else begin
                        checkOutput($sformatf("lane%0d_data", k), {24'b0, dout[k*8 +: 8]}, {24'b0, lane_q[k][0]});
                        if (dout_ready[k]) void'(lane_q[k].pop_front());
                    end
                end else begin
                    checkOutput($sformatf("lane%0d_idle_zero", k), {24'b0, dout[k*8 +: 8]}, 32'd0);
                end
            end
        end
    end

    initial begin
        doReset(2);
        checkState("after_reset", 4'b0000, 32'h0);

`ifdef DEMUX_RR_EN
        applyStimulus(2'd3, 8'h01, 4'b1111, 1'b1, 0);
        applyStimulus(2'd0, 8'h02, 4'b1111, 1'b1, 1);
        applyStimulus(2'd2, 8'h03, 4'b1111, 1'b1, 2);
        applyStimulus(2'd1, 8'h04, 4'b1111, 1'b1, 3);
        applyStimulus(2'd3, 8'h05, 4'b1111, 1'b1, 0);
        checkState("rr_five", 4'b0001, 32'h0000_0005);
        idleCycle(2'd2, 4'b1111);
        checkState("rr_drain", 4'b0000, 32'h0);
        applyStimulus(2'd0, 8'h06, 4'b0000, 1'b1, 1);
        checkState("rr_hold_ptr", 4'b0010, 32'h0000_0600);
        idleCycle(2'd0, 4'b1111);
`else
        applyStimulus(2'd2, 8'hA5, 4'b0000, 1'b1, 2);
        checkState("first_word", 4'b0100, 32'h00A5_0000);

        applyStimulus(2'd2, 8'h5A, 4'b0000, 1'b0, 2);
        checkState("blocked", 4'b0100, 32'h00A5_0000);
        applyStimulus(2'd1, 8'h11, 4'b0000, 1'b1, 1);
        checkState("other_lane", 4'b0110, 32'h00A5_1100);

        idleCycle(2'd0, 4'b0000);
        idleCycle(2'd3, 4'b0000);
        checkState("sel_idle", 4'b0110, 32'h00A5_1100);

        applyStimulus(2'd0, 8'h77, 4'b0000, 1'b1, 0);
        checkState("lane0_fill", 4'b0111, 32'h00A5_1177);
        applyStimulus(2'd0, 8'h3C, 4'b0001, 1'b1, 0);
        checkState("drain_fill", 4'b0111, 32'h00A5_113C);

        applyStimulus(2'd3, 8'h99, 4'b0010, 1'b1, 3);
        checkState("side_drain", 4'b1101, 32'h99A5_003C);

        idleCycle(2'd0, 4'b0100);
        checkState("drain_only", 4'b1001, 32'h9900_003C);

        applyStimulus(2'd1, 8'h42, 4'b0000, 1'b1, 1);
        checkState("pre_reset", 4'b1011, 32'h9900_423C);
        doReset(1);
        checkState("mid_reset", 4'b0000, 32'h0);

        applyStimulus(2'd3, 8'hE1, 4'b0000, 1'b1, 3);
        checkState("first_after_rst", 4'b1000, 32'hE100_0000);
        idleCycle(2'd0, 4'b1111);
        checkState("all_drained", 4'b0000, 32'h0);
`endif

        doReset(1);
        for (int i = 0; i < 65535; i++) begin
            applyStimulus(2'(i % 4), 8'(i), 4'b1111, 1'b1, i % 4);
        end
        checkOutput("cnt_ffff", {16'b0, xfer_cnt}, 32'h0000_FFFF);
        applyStimulus(2'd3, 8'hEE, 4'b1111, 1'b1, 3);
        checkOutput("cnt_wrap", {16'b0, xfer_cnt}, 32'h0000_0000);
        idleCycle(2'd0, 4'b1111);
        idleCycle(2'd0, 4'b1111);
        checkOutput("queues_empty",
                    32'(lane_q[0].size() + lane_q[1].size() + lane_q[2].size() + lane_q[3].size()),
                    32'd0);
        checkOutput("final_valid", {28'b0, dout_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
